// File: rtl/regfile_param.sv
// Parametrised register file: WIDTH-bit x DEPTH entries, two combinational
// read ports, one write port, optional hardwired zero register, optional
// same-cycle write-to-read forwarding, and a one-entry-per-cycle clear sweep
// started by a synchronous reset.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | normal operation, external writes accepted
//   CLEAR | reset sweep, clr_idx walks 0..DEPTH-1 writing zeros; Busy=1

module regfile_param #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter int ZERO_REG = 31,
   parameter bit BYPASS   = 1'b1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [AW-1:0]    RA,
   input  logic [AW-1:0]    RB,
   input  logic [AW-1:0]    RW,
   input  logic [WIDTH-1:0] BusW,
   input  logic             RegWr,
   output logic [WIDTH-1:0] BusA,
   output logic [WIDTH-1:0] BusB,
   output logic             Busy
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t           state, state_nxt;
   logic [AW-1:0]    clr_idx, clr_idx_nxt;
   logic             busy_nxt;

   logic [WIDTH-1:0] mem [DEPTH];

   logic             sweep_wr;
   logic             ext_wr;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;

   // An address is backed by storage when it is in range and not the zero
   // register; a ZERO_REG at or beyond DEPTH therefore never matches.
   function automatic logic addr_live(input logic [AW-1:0] addr);
      return (32'(addr) < 32'(DEPTH)) && (32'(addr) != 32'(ZERO_REG));
   endfunction

   function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] addr);
      logic [WIDTH-1:0] data;
      data = '0;
      if (!Busy && addr_live(addr)) begin
         if (BYPASS && RegWr && (RW == addr))
            data = BusW;
         else
            data = mem[addr];
      end
      return data;
   endfunction

   // State, sweep counter and registered Busy; reset restarts the sweep.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= CLEAR;
         clr_idx <= '0;
         Busy    <= 1'b1;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
         Busy    <= busy_nxt;
      end
   end

   // Next-state logic: walk the sweep counter, leave CLEAR after the last entry.
   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      busy_nxt    = Busy;
      case (state)
         IDLE: begin
            busy_nxt = 1'b0;
         end
         CLEAR: begin
            busy_nxt = 1'b1;
            if (clr_idx == LAST_IDX) begin
               state_nxt   = IDLE;
               clr_idx_nxt = '0;
               busy_nxt    = 1'b0;
            end else begin
               clr_idx_nxt = clr_idx + 1'b1;
            end
         end
         default: begin
            state_nxt   = CLEAR;
            clr_idx_nxt = '0;
            busy_nxt    = 1'b1;
         end
      endcase
   end

   // Single write port shared between the clear sweep and external writes;
   // external writes are refused whenever Busy is up, including the sweep's
   // final cycle and a reset edge.
   always_comb begin
      sweep_wr = (state == CLEAR) && !Reset;
      ext_wr   = !Busy && !Reset && RegWr && addr_live(RW);
      wr_en    = sweep_wr || ext_wr;
      wr_addr  = sweep_wr ? clr_idx : RW;
      wr_data  = sweep_wr ? '0 : BusW;
   end

   // Storage array, no reset: contents are defined by the clear sweep.
   always_ff @(posedge Clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   // Read port A.
   always_comb begin
      BusA = read_port(RA);
   end

   // Read port B.
   always_comb begin
      BusB = read_port(RB);
   end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default instance (64x32, bypass on),
// a no-bypass instance, and a small 16x8 instance with zero register 0.

module tb_regfile_param;

   logic clk;

   int checks;
   int errors;

   // default instance
   logic        reset0, regwr0;
   logic [4:0]  ra0, rb0, rw0;
   logic [63:0] busw0, busa0, busb0;
   logic        busy0;

   // no-bypass instance
   logic        reset1, regwr1;
   logic [4:0]  ra1, rb1, rw1;
   logic [63:0] busw1, busa1, busb1;
   logic        busy1;

   // small instance
   logic        reset2, regwr2;
   logic [2:0]  ra2, rb2, rw2;
   logic [15:0] busw2, busa2, busb2;
   logic        busy2;

   regfile_param dut0 (
      .Clk(clk), .Reset(reset0), .RA(ra0), .RB(rb0), .RW(rw0),
      .BusW(busw0), .RegWr(regwr0), .BusA(busa0), .BusB(busb0), .Busy(busy0)
   );

   regfile_param #(.BYPASS(1'b0)) dut1 (
      .Clk(clk), .Reset(reset1), .RA(ra1), .RB(rb1), .RW(rw1),
      .BusW(busw1), .RegWr(regwr1), .BusA(busa1), .BusB(busb1), .Busy(busy1)
   );

   regfile_param #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut2 (
      .Clk(clk), .Reset(reset2), .RA(ra2), .RB(rb2), .RW(rw2),
      .BusW(busw2), .RegWr(regwr2), .BusA(busa2), .BusB(busb2), .Busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      @(negedge clk);
      reset0 = 1'b1;
      reset1 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_edge_busy: got %b expected 1", busy0);
      end
      @(negedge clk);
      reset0 = 1'b0;
      reset1 = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk); #1;
         checks++;
         if (busy0 !== (k < 32)) begin
            errors++;
            $display("FAIL sweep_busy edge %0d: got %b expected %b", k, busy0, (k < 32));
         end
      end
      checks++;
      if (busy1 !== 1'b0) begin
         errors++;
         $display("FAIL sweep_busy_nobypass: got %b expected 0", busy1);
      end
      @(negedge clk);
      for (int a = 0; a < 32; a++) begin
         ra0 = 5'(a);
         rb0 = 5'(31 - a);
         #1;
         checks++;
         if (busa0 !== 64'h0 || busb0 !== 64'h0) begin
            errors++;
            $display("FAIL cleared_read addr %0d: got %h/%h expected 0", a, busa0, busb0);
         end
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      rw0 = 5'd5; busw0 = 64'hDEAD_BEEF_0123_4567; regwr0 = 1'b1;
      rw1 = 5'd7; busw1 = 64'h0000_0000_0000_0BAD; regwr1 = 1'b1;
      @(negedge clk);
      rw0 = 5'd7; busw0 = 64'h0000_0000_0000_0BAD;
      regwr1 = 1'b0;
      @(negedge clk);
      regwr0 = 1'b0;
      ra0 = 5'd5; rb0 = 5'd5;
      #1;
      checks++;
      if (busa0 !== 64'hDEAD_BEEF_0123_4567) begin
         errors++;
         $display("FAIL write_read_A: got %h expected DEADBEEF01234567", busa0);
      end
      checks++;
      if (busb0 !== 64'hDEAD_BEEF_0123_4567) begin
         errors++;
         $display("FAIL write_read_B: got %h expected DEADBEEF01234567", busb0);
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      regwr0 = 1'b1; rw0 = 5'd7; ra0 = 5'd7; rb0 = 5'd5; busw0 = 64'h1234;
      regwr1 = 1'b1; rw1 = 5'd7; ra1 = 5'd7; busw1 = 64'h1234;
      #1;
      checks++;
      if (busa0 !== 64'h1234) begin
         errors++;
         $display("FAIL bypass_on: got %h expected 1234", busa0);
      end
      checks++;
      if (busb0 !== 64'hDEAD_BEEF_0123_4567) begin
         errors++;
         $display("FAIL bypass_other_port: got %h expected DEADBEEF01234567", busb0);
      end
      checks++;
      if (busa1 !== 64'h0BAD) begin
         errors++;
         $display("FAIL bypass_off_before: got %h expected bad", busa1);
      end
      @(posedge clk); #1;
      checks++;
      if (busa1 !== 64'h1234) begin
         errors++;
         $display("FAIL bypass_off_after: got %h expected 1234", busa1);
      end
      @(negedge clk);
      regwr0 = 1'b0;
      regwr1 = 1'b0;
      #1;
      checks++;
      if (busa0 !== 64'h1234) begin
         errors++;
         $display("FAIL bypass_stored: got %h expected 1234", busa0);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      regwr0 = 1'b1; rw0 = 5'd1; busw0 = 64'h1111_0000_0000_0001;
      @(negedge clk);
      rw0 = 5'd2; busw0 = 64'h2222_0000_0000_0002;
      @(negedge clk);
      rw0 = 5'd3; busw0 = 64'h3333_0000_0000_0003;
      @(negedge clk);
      regwr0 = 1'b0;
      ra0 = 5'd1; rb0 = 5'd2;
      #1;
      checks++;
      if (busa0 !== 64'h1111_0000_0000_0001 || busb0 !== 64'h2222_0000_0000_0002) begin
         errors++;
         $display("FAIL b2b_r1_r2: got %h/%h expected 1111000000000001/2222000000000002", busa0, busb0);
      end
      ra0 = 5'd3; rb0 = 5'd7;
      #1;
      checks++;
      if (busa0 !== 64'h3333_0000_0000_0003 || busb0 !== 64'h1234) begin
         errors++;
         $display("FAIL b2b_r3_r7: got %h/%h expected 3333000000000003/1234", busa0, busb0);
      end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      regwr0 = 1'b1; rw0 = 5'd31; ra0 = 5'd31; rb0 = 5'd31; busw0 = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      checks++;
      if (busa0 !== 64'h0 || busb0 !== 64'h0) begin
         errors++;
         $display("FAIL zero_reg_no_bypass: got %h/%h expected 0", busa0, busb0);
      end
      @(posedge clk); #1;
      checks++;
      if (busa0 !== 64'h0) begin
         errors++;
         $display("FAIL zero_reg_after_edge: got %h expected 0", busa0);
      end
      @(negedge clk);
      regwr0 = 1'b0;
      #1;
      checks++;
      if (busa0 !== 64'h0) begin
         errors++;
         $display("FAIL zero_reg_stored: got %h expected 0", busa0);
      end
   endtask

   task automatic test_mid_sweep();
      @(negedge clk);
      reset0 = 1'b1;
      @(negedge clk);
      reset0 = 1'b0;
      for (int k = 1; k <= 10; k++) @(posedge clk);
      @(negedge clk);
      reset0 = 1'b1;
      regwr0 = 1'b1; rw0 = 5'd3; busw0 = 64'h5555_AAAA_5555_AAAA;
      @(posedge clk); #1;
      checks++;
      if (busy0 !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_busy: got %b expected 1", busy0);
      end
      @(negedge clk);
      reset0 = 1'b0;
      ra0 = 5'd3;
      #1;
      checks++;
      if (busa0 !== 64'h0) begin
         errors++;
         $display("FAIL busy_read_zero: got %h expected 0", busa0);
      end
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk); #1;
         checks++;
         if (busy0 !== (k < 32)) begin
            errors++;
            $display("FAIL resweep_busy edge %0d: got %b expected %b", k, busy0, (k < 32));
         end
      end
      @(negedge clk);
      regwr0 = 1'b0;
      ra0 = 5'd3; rb0 = 5'd5;
      #1;
      checks++;
      if (busa0 !== 64'h0) begin
         errors++;
         $display("FAIL busy_write_lost: got %h expected 0", busa0);
      end
      checks++;
      if (busb0 !== 64'h0) begin
         errors++;
         $display("FAIL resweep_cleared_r5: got %h expected 0", busb0);
      end
   endtask

   task automatic test_small_instance();
      @(negedge clk);
      reset2 = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         checks++;
         if (busy2 !== 1'b1) begin
            errors++;
            $display("FAIL small_reset_held edge %0d: got %b expected 1", k, busy2);
         end
      end
      @(negedge clk);
      reset2 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         checks++;
         if (busy2 !== (k < 8)) begin
            errors++;
            $display("FAIL small_sweep_busy edge %0d: got %b expected %b", k, busy2, (k < 8));
         end
      end
      @(negedge clk);
      regwr2 = 1'b1; rw2 = 3'd7; busw2 = 16'hA5A5;
      @(negedge clk);
      rw2 = 3'd0; busw2 = 16'hFFFF; ra2 = 3'd0; rb2 = 3'd7;
      #1;
      checks++;
      if (busa2 !== 16'h0 || busb2 !== 16'hA5A5) begin
         errors++;
         $display("FAIL small_zero_bypass: got %h/%h expected 0000/a5a5", busa2, busb2);
      end
      @(negedge clk);
      regwr2 = 1'b0;
      ra2 = 3'd7; rb2 = 3'd0;
      #1;
      checks++;
      if (busa2 !== 16'hA5A5 || busb2 !== 16'h0) begin
         errors++;
         $display("FAIL small_readback: got %h/%h expected a5a5/0000", busa2, busb2);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset0 = 1'b0; regwr0 = 1'b0; ra0 = '0; rb0 = '0; rw0 = '0; busw0 = '0;
      reset1 = 1'b0; regwr1 = 1'b0; ra1 = '0; rb1 = '0; rw1 = '0; busw1 = '0;
      reset2 = 1'b0; regwr2 = 1'b0; ra2 = '0; rb2 = '0; rw2 = '0; busw2 = '0;
      test_reset();
      test_write_read();
      test_bypass();
      test_back_to_back();
      test_zero_reg();
      test_mid_sweep();
      test_small_instance();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
